// File: rtl/regfile_pkg.sv
// Shared widths, types and reset value for the 8x16 register file.
package regfile_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_DEPTH  = 2 ** DEF_ADDR_W;

    typedef logic [DEF_DATA_W-1:0] word_t;
    typedef logic [DEF_ADDR_W-1:0] addr_t;

    localparam word_t RESET_VAL = 16'h0000;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: 8-to-1 word select by address.
// With REGFILE_BYPASS_EN defined, a same-cycle write to the addressed register is forwarded.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]                  addr,
`ifdef REGFILE_BYPASS_EN
    input  logic                               rst,
    input  logic                               we,
    input  logic [ADDR_W-1:0]                  wa,
    input  logic [DATA_W-1:0]                  wd,
`endif
    output logic [DATA_W-1:0]                  rd
);

`ifdef REGFILE_BYPASS_EN
    // The write being presented this cycle wins over stored contents; a reset cycle writes nothing.
    always_comb begin
        rd = regs[addr];
        if (we && !rst && (wa == addr)) begin
            rd = wd;
        end
    end
`else
    assign rd = regs[addr];
`endif

endmodule

// File: rtl/register_file_8x16.sv
// Eight-entry, 16-bit register file: one synchronous write port, two combinational read ports.
// Optional write-through forwarding on the read ports under REGFILE_BYPASS_EN.
module register_file_8x16
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra_a,
    input  logic [ADDR_W-1:0] ra_b,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic [DEPTH-1:0]             wen;

    always_comb begin
        wen = '0;
        if (we) begin
            wen[wa] = 1'b1;
        end
    end

    // Reset has priority over any write presented in the same cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                regs[i] <= DATA_W'(RESET_VAL);
            end else if (wen[i]) begin
                regs[i] <= wd;
            end
        end
    end

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port_a (
        .regs (regs),
        .addr (ra_a),
`ifdef REGFILE_BYPASS_EN
        .rst  (rst),
        .we   (we),
        .wa   (wa),
        .wd   (wd),
`endif
        .rd   (rd_a)
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port_b (
        .regs (regs),
        .addr (ra_b),
`ifdef REGFILE_BYPASS_EN
        .rst  (rst),
        .we   (we),
        .wa   (wa),
        .wd   (wd),
`endif
        .rd   (rd_b)
    );

endmodule
